// File: rtl/qos_round_robin_arbiter.sv
// QoS scheduler for the PCIe datapath.
// Issues a registered one-hot queue grant every clock in RR/WRR/TABLE/WTABLE mode.
module qos_round_robin_arbiter #(
   parameter int NQ     = 4,
   parameter int NPHASE = 16
) (
   input  logic [1:0]                    SELECT,
   input  logic                          CLK,
   input  logic [NPHASE*$clog2(NQ)-1:0]  TAB,
   input  logic [1:0]                    W,
   output logic [NQ-1:0]                 OUT,
   input  logic                          ENB
);

   localparam int QW = $clog2(NQ);
   localparam int PW = $clog2(NPHASE);

   logic [NQ-1:0] out_q, out_d;
   logic [QW-1:0] ptr_q, ptr_d;
   logic [PW-1:0] phase_q, phase_d;
   logic [1:0]    cnt_q, cnt_d;
   logic [1:0]    sel_q, sel_d;

   logic [QW-1:0] idx;
   logic [QW-1:0] tab_idx;
   logic [1:0]    cnt_eff;
   logic          hold_done;

   // Pick the granted queue and next pointer/phase/hold state for this edge
   always_comb begin
      cnt_eff   = (SELECT != sel_q) ? 2'd0 : cnt_q;
      hold_done = (cnt_eff >= W);
      tab_idx   = TAB[phase_q*QW +: QW];
      idx       = ptr_q;
      ptr_d     = ptr_q;
      phase_d   = phase_q;
      cnt_d     = 2'd0;
      sel_d     = SELECT;
      case (SELECT)
         2'b00: begin
            ptr_d = ptr_q + 1'b1;
         end
         2'b01: begin
            if (hold_done) ptr_d = ptr_q + 1'b1;
            else           cnt_d = cnt_eff + 1'b1;
         end
         2'b10: begin
            idx     = tab_idx;
            phase_d = phase_q + 1'b1;
         end
         default: begin
            idx = tab_idx;
            if (hold_done) phase_d = phase_q + 1'b1;
            else           cnt_d   = cnt_eff + 1'b1;
         end
      endcase
      out_d      = '0;
      out_d[idx] = 1'b1;
   end

   // State and grant registers; ENB low restarts from queue 0 / phase 0
   always_ff @(posedge CLK) begin
      if (!ENB) begin
         out_q   <= '0;
         ptr_q   <= '0;
         phase_q <= '0;
         cnt_q   <= '0;
         sel_q   <= SELECT;
      end else begin
         out_q   <= out_d;
         ptr_q   <= ptr_d;
         phase_q <= phase_d;
         cnt_q   <= cnt_d;
         sel_q   <= sel_d;
      end
   end

   assign OUT = out_q;

endmodule

// File: tb/tb_qos_round_robin_arbiter.sv
// Directed vector bench for qos_round_robin_arbiter.
// Each record drives one clock edge and names the grant expected after it.
module tb_qos_round_robin_arbiter;

   typedef struct {
      logic        enb;
      logic [1:0]  sel;
      logic [1:0]  w;
      logic [31:0] tab;
      logic [3:0]  exp;
      string       name;
   } vec_t;

   logic        clk;
   logic        enb;
   logic [1:0]  sel;
   logic [1:0]  w;
   logic [31:0] tab;
   logic [3:0]  out;

   int pass_cnt;
   int total_cnt;
   vec_t vt[$];

   qos_round_robin_arbiter dut (
      .SELECT(sel),
      .CLK   (clk),
      .TAB   (tab),
      .W     (w),
      .OUT   (out),
      .ENB   (enb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [3:0] oh(input int q);
      logic [3:0] one;
      one = 4'b0001;
      return one << (q % 4);
   endfunction

   task automatic add(input logic e, input logic [1:0] s,
                      input logic [1:0] ww, input logic [31:0] t,
                      input logic [3:0] x, input string n);
      vec_t v;
      v.enb = e; v.sel = s; v.w = ww; v.tab = t; v.exp = x; v.name = n;
      vt.push_back(v);
   endtask

   task automatic step(input logic e, input logic [1:0] s,
                       input logic [1:0] ww, input logic [31:0] t,
                       input logic [3:0] x, input string n);
      @(negedge clk);
      enb = e; sel = s; w = ww; tab = t;
      @(posedge clk);
      #1;
      total_cnt++;
      if (out === x) pass_cnt++;
      else $display("FAIL %s #%0d: OUT=%b expected %b", n, total_cnt, out, x);
   endtask

   initial begin
      pass_cnt  = 0;
      total_cnt = 0;
      enb = 1'b0; sel = 2'b00; w = 2'd0; tab = '0;

      // Reset with junk inputs, then plain RR with wrap
      add(0, 3, 3, 32'hFFFF_FFFF, 4'b0000, "reset");
      add(0, 3, 3, 32'hFFFF_FFFF, 4'b0000, "reset");
      add(1, 0, 3, 32'hDEAD_BEEF, 4'b0001, "rr");
      add(1, 0, 3, 32'hDEAD_BEEF, 4'b0010, "rr");
      add(1, 0, 3, 32'hDEAD_BEEF, 4'b0100, "rr");
      add(1, 0, 3, 32'hDEAD_BEEF, 4'b1000, "rr");
      add(1, 0, 3, 32'hDEAD_BEEF, 4'b0001, "rr_wrap");

      // WRR W=2: each queue held three cycles
      add(0, 1, 2, 32'h0, 4'b0000, "reset");
      for (int q = 0; q < 4; q++)
         for (int k = 0; k < 3; k++)
            add(1, 1, 2, 32'hDEAD_BEEF, oh(q), "wrr_w2");
      add(1, 1, 2, 32'hDEAD_BEEF, 4'b0001, "wrr_w2_wrap");

      // WRR W=0 behaves like RR
      add(0, 1, 0, 32'h0, 4'b0000, "reset");
      for (int q = 0; q < 5; q++)
         add(1, 1, 0, 32'hDEAD_BEEF, oh(q), "wrr_w0");

      // TABLE with TAB=0x1B
      add(0, 2, 3, 32'h0000_001B, 4'b0000, "reset");
      add(1, 2, 3, 32'h0000_001B, 4'b1000, "tab_p0");
      add(1, 2, 3, 32'h0000_001B, 4'b0100, "tab_p1");
      add(1, 2, 3, 32'h0000_001B, 4'b0010, "tab_p2");
      add(1, 2, 3, 32'h0000_001B, 4'b0001, "tab_p3");
      for (int p = 4; p < 16; p++)
         add(1, 2, 3, 32'h0000_001B, 4'b0001, "tab_hi");
      add(1, 2, 3, 32'h0000_001B, 4'b1000, "tab_wrap");

      // WTABLE W=1, TAB=E4E4E4E4: each phase held two cycles
      add(0, 3, 1, 32'hE4E4_E4E4, 4'b0000, "reset");
      for (int p = 0; p < 17; p++)
         for (int k = 0; k < 2; k++)
            add(1, 3, 1, 32'hE4E4_E4E4, oh(p), "wtab_w1");

      // WRR W=3, switch to RR after two grants of queue 1
      add(0, 1, 3, 32'h0, 4'b0000, "reset");
      for (int k = 0; k < 4; k++) add(1, 1, 3, 32'h0, 4'b0001, "wrr_w3");
      add(1, 1, 3, 32'h0, 4'b0010, "wrr_w3_q1");
      add(1, 1, 3, 32'h0, 4'b0010, "wrr_w3_q1");
      add(1, 0, 3, 32'h0, 4'b0010, "switch_rr");
      add(1, 0, 3, 32'h0, 4'b0100, "switch_rr");
      add(1, 0, 3, 32'h0, 4'b1000, "switch_rr");
      add(1, 0, 3, 32'h0, 4'b0001, "switch_rr");

      // Lowering W below the running count ends the hold next edge
      add(0, 1, 3, 32'h0, 4'b0000, "reset");
      for (int k = 0; k < 3; k++) add(1, 1, 3, 32'h0, 4'b0001, "wlow_pre");
      add(1, 1, 1, 32'h0, 4'b0001, "wlow_cut");
      add(1, 1, 1, 32'h0, 4'b0010, "wlow_q1");
      add(1, 1, 1, 32'h0, 4'b0010, "wlow_q1");
      add(1, 1, 1, 32'h0, 4'b0100, "wlow_q2");

      // Reset in TABLE mode at phase 7
      add(0, 2, 0, 32'h0000_C002, 4'b0000, "reset");
      add(1, 2, 0, 32'h0000_C002, 4'b0100, "midrst_p0");
      for (int p = 1; p < 7; p++)
         add(1, 2, 0, 32'h0000_C002, 4'b0001, "midrst_run");
      add(0, 2, 0, 32'h0000_C002, 4'b0000, "midrst_reset");
      add(1, 2, 0, 32'h0000_C002, 4'b0100, "midrst_p0_again");
      add(1, 2, 0, 32'h0000_C002, 4'b0001, "midrst_p1");

      foreach (vt[i])
         step(vt[i].enb, vt[i].sel, vt[i].w, vt[i].tab, vt[i].exp, vt[i].name);

      // TAB rewritten mid-run applies to the phase read on that edge
      step(0, 2, 0, 32'h0000_0000, 4'b0000, "reset");
      step(1, 2, 0, 32'h0000_0000, 4'b0001, "tabchg_p0");
      step(1, 2, 0, 32'h0000_000C, 4'b1000, "tabchg_p1");
      step(1, 2, 0, 32'h0000_0030, 4'b1000, "tabchg_p2");
      step(1, 2, 0, 32'h0000_0030, 4'b0001, "tabchg_p3");

      // Mode change WTABLE -> TABLE keeps the phase
      step(0, 3, 2, 32'h0000_0024, 4'b0000, "reset");
      step(1, 3, 2, 32'h0000_0024, 4'b0001, "wt_p0");
      step(1, 3, 2, 32'h0000_0024, 4'b0001, "wt_p0");
      step(1, 3, 2, 32'h0000_0024, 4'b0001, "wt_p0");
      step(1, 3, 2, 32'h0000_0024, 4'b0010, "wt_p1");
      step(1, 2, 2, 32'h0000_0024, 4'b0010, "wt_to_tab_p1");
      step(1, 2, 2, 32'h0000_0024, 4'b0100, "wt_to_tab_p2");

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
